// File: rtl/ps2_pkg.sv
// Shared types and frame layout for the PS/2 keyboard receiver.
// Bit positions index the 11-bit frame in arrival order (start first).
package ps2_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      CHECK = 2'd2
   } state_t;

   localparam int FRAME_BITS = 11;
   localparam int START_BIT  = 0;
   localparam int DATA_LSB   = 1;
   localparam int DATA_MSB   = 8;
   localparam int PARITY_BIT = 9;
   localparam int STOP_BIT   = 10;

   // Odd parity holds when data plus parity carry an odd number of ones.
   function automatic logic odd_ok(input logic [8:0] bits);
      return ^bits;
   endfunction

endpackage

// File: rtl/ps2_filter.sv
// Two-flop synchroniser, run-length deglitch filter and falling-edge pulse
// for one raw PS/2 line. Idles high, as the open-collector bus does.
module ps2_filter #(
   parameter int FILTER_LEN = 4
) (
   input  logic clk,
   input  logic reset_n,
   input  logic raw,
   output logic filt,
   output logic fall
);

   localparam logic [3:0] LAST = 4'(FILTER_LEN - 1);

   logic       s1;
   logic       s2;
   logic       filt_d;
   logic [3:0] cnt;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         s1     <= 1'b1;
         s2     <= 1'b1;
         cnt    <= 4'd0;
         filt   <= 1'b1;
         filt_d <= 1'b1;
         fall   <= 1'b0;
      end else begin
         s1     <= raw;
         s2     <= s1;
         filt_d <= filt;
         fall   <= filt_d & ~filt;
         // Any sample that agrees with the current output restarts the run.
         if (s2 == filt) begin
            cnt <= 4'd0;
         end else if (cnt == LAST) begin
            filt <= s2;
            cnt  <= 4'd0;
         end else begin
            cnt <= cnt + 4'd1;
         end
      end
   end

endmodule

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receive stage: filters the pins, deframes 11-bit frames
// and queues good scan-code bytes in a show-ahead FIFO for the CPU.
module ps2_kbd_rx
   import ps2_pkg::*;
#(
   parameter int FILTER_LEN  = 4,
   parameter int TIMEOUT_CYC = 8000,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   input  logic       rd,
   output logic [7:0] data,
   output logic       valid,
   output logic       overflow,
   output logic       parity_err,
   output logic       frame_err,
   input  logic       err_clr
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);

   logic c_filt;
   logic c_fall;
   logic d_filt;
   logic d_fall;
   logic unused_sig;

   ps2_filter #(
      .FILTER_LEN(FILTER_LEN)
   ) u_clk_filt (
      .clk    (clk),
      .reset_n(reset_n),
      .raw    (ps2_clk),
      .filt   (c_filt),
      .fall   (c_fall)
   );

   ps2_filter #(
      .FILTER_LEN(FILTER_LEN)
   ) u_data_filt (
      .clk    (clk),
      .reset_n(reset_n),
      .raw    (ps2_data),
      .filt   (d_filt),
      .fall   (d_fall)
   );

   assign unused_sig = c_filt ^ d_fall;

   state_t                state;
   state_t                state_nx;
   logic [FRAME_BITS-1:0] frame;
   logic [3:0]            bitcnt;
   logic [TW-1:0]         timer;
   logic                  start;
   logic                  timeout;
   logic                  push;
   logic                  set_perr;
   logic                  set_ferr;

   assign start   = (state == IDLE) && c_fall && !d_filt;
   assign timeout = (state == SHIFT) && !c_fall && (timer == T_LAST);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: begin
            if (start) begin
               state_nx = SHIFT;
            end
         end
         SHIFT: begin
            if (timeout) begin
               state_nx = IDLE;
            end else if (c_fall && bitcnt == 4'd9) begin
               state_nx = CHECK;
            end
         end
         CHECK: begin
            state_nx = IDLE;
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   // A bad stop bit outranks a parity error when both are wrong.
   always_comb begin
      push     = 1'b0;
      set_perr = 1'b0;
      set_ferr = 1'b0;
      unique case (state)
         SHIFT: begin
            set_ferr = timeout;
         end
         CHECK: begin
            if (!frame[STOP_BIT]) begin
               set_ferr = 1'b1;
            end else if (!odd_ok(frame[PARITY_BIT:DATA_LSB])) begin
               set_perr = 1'b1;
            end else begin
               push = 1'b1;
            end
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         frame  <= '0;
         bitcnt <= 4'd0;
         timer  <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start) begin
                  frame  <= {d_filt, frame[FRAME_BITS-1:1]};
                  bitcnt <= 4'd0;
                  timer  <= '0;
               end
            end
            SHIFT: begin
               if (c_fall) begin
                  frame  <= {d_filt, frame[FRAME_BITS-1:1]};
                  bitcnt <= bitcnt + 4'd1;
                  timer  <= '0;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   logic [7:0]  mem [FIFO_DEPTH];
   logic [AW:0] wp;
   logic [AW:0] rp;
   logic        full;
   logic        do_pop;
   logic        do_push;
   logic        ovf_set;

   assign valid   = (wp != rp);
   assign full    = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
   assign do_pop  = rd && valid;
   // A pop in the same cycle frees the slot a full FIFO needs.
   assign do_push = push && (!full || do_pop);
   assign ovf_set = push && full && !do_pop;
   assign data    = valid ? mem[rp[AW-1:0]] : 8'h00;

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wp[AW-1:0]] <= frame[DATA_MSB:DATA_LSB];
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wp <= '0;
         rp <= '0;
      end else begin
         if (do_push) begin
            wp <= wp + 1'b1;
         end
         if (do_pop) begin
            rp <= rp + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         overflow   <= 1'b0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         if (ovf_set) begin
            overflow <= 1'b1;
         end else if (err_clr) begin
            overflow <= 1'b0;
         end
         if (set_perr) begin
            parity_err <= 1'b1;
         end else if (err_clr) begin
            parity_err <= 1'b0;
         end
         if (set_ferr) begin
            frame_err <= 1'b1;
         end else if (err_clr) begin
            frame_err <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Bench for ps2_kbd_rx: table vectors, directed corner sequences and
// random frames checked against a frame-level queue model.
module tb_ps2_kbd_rx;

   localparam int FLT   = 4;
   localparam int TMO   = 400;
   localparam int DEPTH = 4;
   localparam int HALF  = 40;
   localparam int GAP   = 60;

   logic       clk;
   logic       reset_n;
   logic       ps2_clk;
   logic       ps2_data;
   logic       rd;
   logic [7:0] data;
   logic       valid;
   logic       overflow;
   logic       parity_err;
   logic       frame_err;
   logic       err_clr;

   ps2_kbd_rx #(
      .FILTER_LEN (FLT),
      .TIMEOUT_CYC(TMO),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .ps2_clk   (ps2_clk),
      .ps2_data  (ps2_data),
      .rd        (rd),
      .data      (data),
      .valid     (valid),
      .overflow  (overflow),
      .parity_err(parity_err),
      .frame_err (frame_err),
      .err_clr   (err_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int ntests = 0;
   int nfail  = 0;

   logic [7:0] mq[$];
   bit         m_ovf;
   bit         m_par;
   bit         m_frm;

   typedef struct {
      logic [7:0] b;
      bit         pflip;
      bit         stopv;
      bit         exp_valid;
      logic [7:0] exp_data;
      bit         exp_perr;
      bit         exp_ferr;
   } vec_t;

   vec_t vt[6];

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk(input string nm, input logic [31:0] got,
                      input logic [31:0] exp);
      ntests++;
      if (got !== exp) begin
         nfail++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask

   function automatic logic [10:0] build(input logic [7:0] b,
                                         input bit pflip, input bit stopv);
      logic [10:0] f;
      f[0]   = 1'b0;
      f[8:1] = b;
      f[9]   = ~(^b) ^ pflip;
      f[10]  = stopv;
      return f;
   endfunction

   // Frame-level reference: what a receiver must do with a whole frame.
   task automatic model_frame(input logic [10:0] f);
      if (f[10] == 1'b0) begin
         m_frm = 1'b1;
      end else if ((^f[9:1]) != 1'b1) begin
         m_par = 1'b1;
      end else if (mq.size() >= DEPTH) begin
         m_ovf = 1'b1;
      end else begin
         mq.push_back(f[8:1]);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_ovf = 1'b0;
      m_par = 1'b0;
      m_frm = 1'b0;
   endtask

   task automatic send_bits(input logic [10:0] f, input int first,
                            input int last, input int glitch_at);
      for (int i = first; i <= last; i++) begin
         ps2_data = f[i];
         if (i == glitch_at) begin
            tick(10);
            ps2_clk = 1'b0;
            tick(FLT - 1);
            ps2_clk = 1'b1;
            tick(HALF - 10 - (FLT - 1));
         end else begin
            tick(HALF);
         end
         ps2_clk = 1'b0;
         tick(HALF);
         ps2_clk = 1'b1;
      end
   endtask

   task automatic send_frame(input logic [7:0] b, input bit pflip,
                             input bit stopv, input int glitch_at);
      logic [10:0] f;
      f = build(b, pflip, stopv);
      send_bits(f, 0, 10, glitch_at);
      ps2_data = 1'b1;
      tick(GAP);
      model_frame(f);
   endtask

   // Ends 8 edges after the stop-bit pin fall: the frame is being checked.
   task automatic stop_to_check(input logic [10:0] f);
      ps2_data = f[10];
      tick(HALF);
      ps2_clk = 1'b0;
      tick(8);
   endtask

   task automatic stop_done();
      tick(HALF - 9);
      ps2_clk  = 1'b1;
      ps2_data = 1'b1;
      tick(GAP);
   endtask

   task automatic chk_flags(input string nm);
      chk({nm, " overflow"}, overflow, m_ovf);
      chk({nm, " parity_err"}, parity_err, m_par);
      chk({nm, " frame_err"}, frame_err, m_frm);
   endtask

   task automatic drain(input string nm);
      logic [7:0] e;
      while (mq.size() > 0) begin
         e = mq.pop_front();
         chk({nm, " valid"}, valid, 1);
         chk({nm, " data"}, data, e);
         rd = 1'b1;
         tick(1);
         rd = 1'b0;
      end
      chk({nm, " empty"}, valid, 0);
   endtask

   task automatic clear_err(input string nm);
      err_clr = 1'b1;
      tick(1);
      err_clr = 1'b0;
      m_ovf = 1'b0;
      m_par = 1'b0;
      m_frm = 1'b0;
      chk_flags({nm, " clr"});
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [10:0] f;
      logic [7:0]  b;
      logic [7:0]  five[5];
      bit          pf;
      bit          sv;

      vt[0] = '{8'hF0, 1'b0, 1'b1, 1'b1, 8'hF0, 1'b0, 1'b0};
      vt[1] = '{8'h1C, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
      vt[2] = '{8'h5A, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1};
      vt[3] = '{8'h00, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0};
      vt[4] = '{8'hFF, 1'b0, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0};
      vt[5] = '{8'h29, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1};

      reset_n  = 1'b0;
      ps2_clk  = 1'b1;
      ps2_data = 1'b1;
      rd       = 1'b0;
      err_clr  = 1'b0;
      model_reset();
      tick(3);
      chk("rst valid", valid, 0);
      chk("rst data", data, 8'h00);
      chk_flags("rst");
      reset_n = 1'b1;
      tick(5);

      // Clean 0x1C with exact byte latency from the stop-bit pin fall.
      f = build(8'h1C, 1'b0, 1'b1);
      send_bits(f, 0, 9, -1);
      stop_to_check(f);
      chk("lat pre valid", valid, 0);
      tick(1);
      chk("lat valid", valid, 1);
      chk("lat data", data, 8'h1C);
      chk_flags("lat");
      stop_done();
      rd = 1'b1;
      tick(1);
      rd = 1'b0;
      chk("lat pop valid", valid, 0);

      rd = 1'b1;
      tick(3);
      rd = 1'b0;
      chk("empty rd valid", valid, 0);

      for (int i = 0; i < 6; i++) begin
         send_frame(vt[i].b, vt[i].pflip, vt[i].stopv, -1);
         chk($sformatf("vec%0d valid", i), valid, vt[i].exp_valid);
         if (vt[i].exp_valid) begin
            chk($sformatf("vec%0d data", i), data, vt[i].exp_data);
         end
         chk($sformatf("vec%0d perr", i), parity_err, vt[i].exp_perr);
         chk($sformatf("vec%0d ferr", i), frame_err, vt[i].exp_ferr);
         drain($sformatf("vec%0d", i));
         clear_err($sformatf("vec%0d", i));
      end

      send_frame(8'hF0, 1'b0, 1'b1, -1);
      send_frame(8'h1C, 1'b0, 1'b1, -1);
      chk("b2b data", data, 8'hF0);
      drain("b2b");

      // Start plus five data bits, then the keyboard goes quiet.
      f = build(8'h77, 1'b0, 1'b1);
      send_bits(f, 0, 5, -1);
      ps2_data = 1'b1;
      chk("tmo early ferr", frame_err, 0);
      tick(TMO + 10);
      m_frm = 1'b1;
      chk("tmo ferr", frame_err, 1);
      chk("tmo valid", valid, 0);
      send_frame(8'h5A, 1'b0, 1'b1, -1);
      chk("tmo next data", data, 8'h5A);
      chk_flags("tmo next");
      drain("tmo");
      clear_err("tmo");

      five = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
      for (int i = 0; i < 5; i++) begin
         send_frame(five[i], 1'b0, 1'b1, (i == 1) ? 4 : -1);
      end
      chk("ovf flag", overflow, 1);
      chk_flags("ovf");
      chk("ovf head", data, 8'h11);
      drain("ovf");
      clear_err("ovf");

      // Full FIFO with a pop in the very cycle of the push.
      for (int i = 0; i < 4; i++) begin
         send_frame(five[i], 1'b0, 1'b1, -1);
      end
      f = build(8'h66, 1'b0, 1'b1);
      send_bits(f, 0, 9, -1);
      stop_to_check(f);
      chk("pp head", data, mq[0]);
      void'(mq.pop_front());
      rd = 1'b1;
      tick(1);
      rd = 1'b0;
      mq.push_back(8'h66);
      chk("pp overflow", overflow, 0);
      stop_done();
      chk_flags("pp");
      drain("pp");

      // Parity error raised in the same cycle as err_clr must stick.
      f = build(8'h44, 1'b1, 1'b1);
      send_bits(f, 0, 9, -1);
      stop_to_check(f);
      err_clr = 1'b1;
      tick(1);
      err_clr = 1'b0;
      chk("setwin perr", parity_err, 1);
      stop_done();
      m_par = 1'b1;
      chk_flags("setwin");

      send_frame(8'h12, 1'b0, 1'b1, -1);
      f = build(8'h33, 1'b0, 1'b1);
      send_bits(f, 0, 3, -1);
      reset_n = 1'b0;
      tick(1);
      reset_n = 1'b1;
      model_reset();
      chk("mid rst valid", valid, 0);
      chk("mid rst data", data, 8'h00);
      chk_flags("mid rst");
      ps2_data = 1'b1;
      tick(GAP);
      send_frame(8'h29, 1'b0, 1'b1, -1);
      chk("mid rst next", data, 8'h29);
      chk_flags("mid rst next");
      drain("mid rst");

      for (int i = 0; i < 16; i++) begin
         b  = 8'($urandom);
         pf = ($urandom_range(0, 4) == 0);
         sv = ($urandom_range(0, 5) != 0);
         send_frame(b, pf, sv, -1);
         chk($sformatf("rnd%0d valid", i), valid, mq.size() != 0);
         chk_flags($sformatf("rnd%0d", i));
         for (int k = $urandom_range(0, 2); k > 0 && mq.size() > 0; k--) begin
            chk($sformatf("rnd%0d pop", i), data, mq.pop_front());
            rd = 1'b1;
            tick(1);
            rd = 1'b0;
         end
         if ($urandom_range(0, 3) == 0) begin
            clear_err($sformatf("rnd%0d", i));
         end
      end
      drain("rnd end");

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
